// File: rtl/udma_pkg.sv
// Shared uDMA channel types: datasize encoding, channel data word, unpacker state.
package udma_pkg;

    typedef logic [1:0] ch_datasize_t;

    localparam ch_datasize_t DS_BYTE = 2'd0;
    localparam ch_datasize_t DS_HALF = 2'd1;
    localparam ch_datasize_t DS_WORD = 2'd2;

    localparam int CH_DATA_WIDTH = 32;

    typedef logic [CH_DATA_WIDTH-1:0] ch_data_t;

    typedef enum logic {
        UNP_IDLE  = 1'b0,
        UNP_SHIFT = 1'b1
    } unp_state_t;

    // Encoding 3 behaves as a full word.
    function automatic logic [2:0] ds_bytes(input ch_datasize_t ds);
        case (ds)
            DS_BYTE: return 3'd1;
            DS_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/udma_tx_unpack_fifo.sv
// Synchronous word FIFO with occupancy count and single-cycle flush.
module udma_tx_unpack_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [AW:0]      count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rd_ptr];
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= data_i;
    end

    // The credit scheme reserves a slot for every grant, so this must never fire.
    always_ff @(posedge clk_i) begin
        if (rstn_i && !flush_i) begin
            assert (!(push_i && full)) else $error("udma_tx_unpack_fifo: push while full");
        end
    end

endmodule

// File: rtl/udma_tx_unpacker.sv
// uDMA TX channel peripheral side: credit-limited requests, word FIFO, byte unpacker.
// Define UDMA_TX_UNPACK_BIG_ENDIAN_EN for MSB-first byte order within the active width.
//
// state     | meaning
// UNP_IDLE  | no word loaded; waiting for the FIFO to become non-empty
// UNP_SHIFT | word loaded; presenting bytes until bytes_left reaches zero
module udma_tx_unpacker
    import udma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    input  logic [1:0]            cfg_datasize_i,
    output logic                  tx_req_o,
    input  logic                  tx_gnt_i,
    input  logic                  tx_valid_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ready_o,
    output logic [1:0]            tx_datasize_o,
    output logic [7:0]            byte_data_o,
    output logic                  byte_valid_o,
    input  logic                  byte_ready_i,
    output logic                  busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]         outst_q;
    logic [CW-1:0]         drop_q;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credit_used;
    logic                  fifo_empty;
    logic [DATA_WIDTH+1:0] fifo_rdata;
    ch_datasize_t          rd_ds;
    ch_data_t              rd_data;
    logic                  grant;
    logic                  accept;
    logic                  dropping;
    logic                  push;
    logic                  pop;
    logic                  fire;
    logic                  last;
    unp_state_t            state_q;
    unp_state_t            state_d;
    ch_data_t              word_q;
    ch_data_t              word_load;
    ch_data_t              word_shift;
    logic [7:0]            word_byte;
    logic [2:0]            bytes_left_q;

    assign dropping      = (drop_q != '0);
    assign credit_used   = {1'b0, fifo_count} + {1'b0, outst_q};
    assign tx_req_o      = rstn_i & cfg_en_i & ~cfg_clr_i & ~dropping &
                           (credit_used < (CW+1)'(FIFO_DEPTH));
    assign tx_ready_o    = rstn_i;
    assign tx_datasize_o = cfg_datasize_i;
    assign grant         = tx_req_o & tx_gnt_i;
    assign accept        = tx_valid_i & tx_ready_o;
    assign push          = accept & ~dropping & ~cfg_clr_i;
    assign {rd_ds, rd_data} = fifo_rdata;

    // A word accepted in the clear cycle is already covered by outst, so drop excludes it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            outst_q <= '0;
            drop_q  <= '0;
        end else if (cfg_clr_i) begin
            outst_q <= '0;
            drop_q  <= drop_q + outst_q - CW'(accept);
        end else begin
            outst_q <= outst_q + CW'(grant) - CW'(accept & ~dropping);
            drop_q  <= drop_q - CW'(accept & dropping);
        end
    end

    udma_tx_unpack_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (cfg_clr_i),
        .push_i  (push),
        .data_i  ({cfg_datasize_i, tx_data_i}),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

`ifdef UDMA_TX_UNPACK_BIG_ENDIAN_EN
    always_comb begin
        case (rd_ds)
            DS_BYTE: word_load = {rd_data[7:0],  {(CH_DATA_WIDTH-8){1'b0}}};
            DS_HALF: word_load = {rd_data[15:0], {(CH_DATA_WIDTH-16){1'b0}}};
            default: word_load = rd_data;
        endcase
    end
    assign word_shift = word_q << 8;
    assign word_byte  = word_q[CH_DATA_WIDTH-1 -: 8];
`else
    assign word_load  = rd_data;
    assign word_shift = word_q >> 8;
    assign word_byte  = word_q[7:0];
`endif

    assign last = (bytes_left_q == 3'd1);
    assign fire = byte_valid_o & byte_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= UNP_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cfg_clr_i) begin
            state_d = UNP_IDLE;
        end else begin
            case (state_q)
                UNP_IDLE:  if (!fifo_empty) state_d = UNP_SHIFT;
                UNP_SHIFT: if (fire && last && fifo_empty) state_d = UNP_IDLE;
                default:   state_d = UNP_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_valid_o = (state_q == UNP_SHIFT);
        byte_data_o  = (state_q == UNP_SHIFT) ? word_byte : 8'h00;
        pop          = ~cfg_clr_i & ~fifo_empty &
                       ((state_q == UNP_IDLE) || ((state_q == UNP_SHIFT) && fire && last));
        busy_o       = (outst_q != '0) | dropping | ~fifo_empty | (state_q == UNP_SHIFT);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            word_q       <= '0;
            bytes_left_q <= '0;
        end else if (cfg_clr_i) begin
            bytes_left_q <= '0;
        end else if (pop) begin
            word_q       <= word_load;
            bytes_left_q <= ds_bytes(rd_ds);
        end else if (fire) begin
            word_q       <= word_shift;
            bytes_left_q <= bytes_left_q - 3'd1;
        end
    end

endmodule

// File: tb/tb_udma_tx_unpacker.sv
// Directed bench for udma_tx_unpacker with a small core model and byte scoreboard.
module tb_udma_tx_unpacker;
    import udma_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        cfg_en_i = 1'b0;
    logic        cfg_clr_i = 1'b0;
    logic [1:0]  cfg_datasize_i = DS_WORD;
    logic        tx_req_o;
    logic        tx_gnt_i = 1'b0;
    logic        tx_valid_i = 1'b0;
    logic [31:0] tx_data_i = '0;
    logic        tx_ready_o;
    logic [1:0]  tx_datasize_o;
    logic [7:0]  byte_data_o;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b0;
    logic        busy_o;

    udma_tx_unpacker #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .cfg_en_i       (cfg_en_i),
        .cfg_clr_i      (cfg_clr_i),
        .cfg_datasize_i (cfg_datasize_i),
        .tx_req_o       (tx_req_o),
        .tx_gnt_i       (tx_gnt_i),
        .tx_valid_i     (tx_valid_i),
        .tx_data_i      (tx_data_i),
        .tx_ready_o     (tx_ready_o),
        .tx_datasize_o  (tx_datasize_o),
        .byte_data_o    (byte_data_o),
        .byte_valid_o   (byte_valid_o),
        .byte_ready_i   (byte_ready_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          gnt_budget = 0;
    int          lat = 0;
    bit          rdy_en = 1'b0;
    int          n_gnt = 0;
    int          n_val = 0;
    int          max_os = 0;
    int          v_cyc = -1;
    logic [31:0] src[$];
    logic [31:0] pend[$];
    int          due[$];
    logic [7:0]  rx[$];
    int          rx_cyc[$];
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] w, input logic [1:0] ds);
        int n;
        n = (ds == DS_BYTE) ? 1 : (ds == DS_HALF) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
`ifdef UDMA_TX_UNPACK_BIG_ENDIAN_EN
            exp_q.push_back(w[8*(n-1-i) +: 8]);
`else
            exp_q.push_back(w[8*i +: 8]);
`endif
        end
    endtask

    // One clock cycle: drive core/peripheral side, observe handshakes, advance.
    task automatic tick();
        logic g, v, b;
        logic [7:0]  bd;
        logic [31:0] w;
        #1;
        tx_gnt_i = tx_req_o && (gnt_budget > 0);
        if (pend.size() > 0 && due[0] <= cyc) begin
            tx_valid_i = 1'b1;
            tx_data_i  = pend[0];
        end else begin
            tx_valid_i = 1'b0;
            tx_data_i  = '0;
        end
        byte_ready_i = rdy_en;
        #1;
        g  = tx_req_o & tx_gnt_i;
        v  = tx_valid_i & tx_ready_o;
        b  = byte_valid_o & byte_ready_i;
        bd = byte_data_o;
        @(posedge clk_i);
        #1;
        cyc++;
        if (g) begin
            n_gnt++;
            gnt_budget--;
            w = (src.size() > 0) ? src.pop_front() : 32'hDEAD0000 + n_gnt;
            pend.push_back(w);
            due.push_back(cyc + lat);
            expect_word(w, cfg_datasize_i);
        end
        if (v) begin
            n_val++;
            void'(pend.pop_front());
            void'(due.pop_front());
            v_cyc = cyc;
        end
        if (n_gnt - n_val > max_os) max_os = n_gnt - n_val;
        if (b) begin
            rx.push_back(bd);
            rx_cyc.push_back(cyc);
        end
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, rx.size(), exp_q.size());
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), rx[i], exp_q[i]);
    endtask

    task automatic new_test();
        rx.delete();
        rx_cyc.delete();
        exp_q.delete();
        src.delete();
        n_gnt = 0;
        n_val = 0;
        max_os = 0;
    endtask

    initial begin
        int bv_first;
        int req_leak;
        bit req_seen;

        // reset, with enable already asserted
        rstn_i = 1'b0;
        cfg_en_i = 1'b1;
        cfg_datasize_i = DS_HALF;
        repeat (3) tick();
        check("rst_tx_req", tx_req_o, 0);
        check("rst_tx_ready", tx_ready_o, 0);
        check("rst_byte_valid", byte_valid_o, 0);
        check("rst_byte_data", byte_data_o, 8'h00);
        check("rst_busy", busy_o, 0);
        check("rst_datasize", tx_datasize_o, 2'd1);
        cfg_en_i = 1'b0;
        cfg_datasize_i = DS_WORD;
        rstn_i = 1'b1;
        tick();
        check("post_rst_tx_ready", tx_ready_o, 1);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_datasize", tx_datasize_o, 2'd2);

        // single word, latency and consecutive bytes
        new_test();
        rdy_en = 1'b1;
        lat = 0;
        src.push_back(32'h44332211);
        gnt_budget = 1;
        cfg_en_i = 1'b1;
        bv_first = -1;
        v_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bv_first < 0 && byte_valid_o) bv_first = cyc;
        end
        cfg_en_i = 1'b0;
        compare_rx("word");
`ifdef UDMA_TX_UNPACK_BIG_ENDIAN_EN
        if (rx.size() > 0) check("word_first_byte", rx[0], 8'h44);
`else
        if (rx.size() > 0) check("word_first_byte", rx[0], 8'h11);
`endif
        check("word_latency", bv_first - v_cyc, 1);
        if (rx.size() == 4) check("word_consecutive", rx_cyc[3] - rx_cyc[0], 3);
        else check("word_rx_len", rx.size(), 4);
        check("word_idle_busy", busy_o, 0);

        // stalled peripheral: credit caps grants at FIFO plus the loaded word
        new_test();
        rdy_en = 1'b0;
        for (int i = 0; i < 10; i++) src.push_back(32'h03020100 + i * 32'h04040404);
        gnt_budget = 10;
        cfg_en_i = 1'b1;
        repeat (20) tick();
        check("stall_grants", n_gnt, 5);
        check("stall_tx_req", tx_req_o, 0);
        check("stall_byte_valid", byte_valid_o, 1);
        if (exp_q.size() > 0) check("stall_byte_hold", byte_data_o, exp_q[0]);
        check("stall_busy", busy_o, 1);
        check("stall_max_outst", max_os <= 4, 1);
        rdy_en = 1'b1;
        req_seen = 1'b0;
        for (int i = 0; i < 200 && rx.size() < 40; i++) begin
            tick();
            if (tx_req_o) req_seen = 1'b1;
        end
        cfg_en_i = 1'b0;
        check("stall_resume_req", req_seen, 1);
        check("stall_total_grants", n_gnt, 10);
        compare_rx("stall");
        repeat (4) tick();

        // half mode, upper halves ignored, no bubble between words
        new_test();
        cfg_datasize_i = DS_HALF;
        src.push_back(32'hAAAA5678);
        src.push_back(32'hBBBB9ABC);
        gnt_budget = 2;
        cfg_en_i = 1'b1;
        repeat (20) tick();
        cfg_en_i = 1'b0;
        compare_rx("half");
`ifdef UDMA_TX_UNPACK_BIG_ENDIAN_EN
        if (rx.size() == 4) check("half_byte2", rx[2], 8'h9A);
`else
        if (rx.size() == 4) check("half_byte2", rx[2], 8'hBC);
`endif
        if (rx.size() == 4) check("half_no_bubble", rx_cyc[3] - rx_cyc[0], 3);
        else check("half_rx_len", rx.size(), 4);
        cfg_datasize_i = DS_WORD;
        tick();

        // clear with three grants outstanding and bytes pending
        new_test();
        rdy_en = 1'b0;
        lat = 0;
        gnt_budget = 1;
        cfg_en_i = 1'b1;
        for (int i = 0; i < 10 && !byte_valid_o; i++) tick();
        check("clr_pre_valid", byte_valid_o, 1);
        lat = 30;
        gnt_budget = 3;
        for (int i = 0; i < 10 && n_gnt < 4; i++) tick();
        check("clr_pre_grants", n_gnt, 4);
        gnt_budget = 0;
        cfg_clr_i = 1'b1;
        tick();
        cfg_clr_i = 1'b0;
        rdy_en = 1'b1;
        check("clr_byte_valid", byte_valid_o, 0);
        check("clr_busy", busy_o, 1);
        check("clr_tx_req", tx_req_o, 0);
        req_leak = 0;
        for (int i = 0; i < 60 && pend.size() > 0; i++) begin
            tick();
            if (pend.size() > 0 && (tx_req_o || !busy_o)) req_leak++;
        end
        check("clr_req_held", req_leak, 0);
        check("clr_discarded", n_val, 4);
        check("clr_busy_after", busy_o, 0);
        check("clr_req_after", tx_req_o, 1);
        check("clr_no_bytes", rx.size(), 0);
        cfg_en_i = 1'b0;
        lat = 0;
        tick();

        // steady stream of 100 random words
        new_test();
        exp_q.delete();
        rdy_en = 1'b1;
        lat = 1;
        for (int i = 0; i < 100; i++) src.push_back($urandom());
        gnt_budget = 100;
        cfg_en_i = 1'b1;
        for (int i = 0; i < 1500 && rx.size() < 400; i++) tick();
        cfg_en_i = 1'b0;
        compare_rx("stream");
        check("stream_grants", n_gnt, 100);
        check("stream_max_outst", max_os <= 4, 1);
        if (rx.size() == 400) check("stream_no_bubble", rx_cyc[399] - rx_cyc[0], 399);
        repeat (3) tick();
        check("stream_idle", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
